fdc_stub: RTL and testbench

- Register-level uPD765 stub for the +3 disk ports, taking over the bus slot that currently returns a constant 0xFF.
- Decodes CPU I/O cycles to 0x2FFD (main status register, MSR) and 0x3FFD (data register).
- Runs the uPD765 command/result handshake and always reports "drive not ready / no media", so +3DOS times out cleanly instead of hanging.
- dout/oe feed the CPU data-bus read mux.

---
 rtl/fdc_stub.sv | 227 ++++++++++++++++++++++
 tb/tb_fdc_stub.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fdc_stub.sv
// Register-level uPD765 stub for the +3 disk ports (MSR at 0x2FFD, data at 0x3FFD) that always reports no drive/media.
// Optional motor latch at 0x1FFD is enabled by defining FDC_MOTOR_PORT_EN.
module fdc_stub #(
    parameter int NCMD_MAX = 9
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] a,
    input  logic        iorq_n,
    input  logic        rd_n,
    input  logic        wr_n,
    input  logic [7:0]  din,
    output logic [7:0]  dout,
    output logic        oe,
    output logic        int_pending,
    output logic        motor_on
);

    localparam int CW = (NCMD_MAX > 1) ? $clog2(NCMD_MAX) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CMD,
        S_RESULT
    } state_t;

    state_t          r_state;
    logic            r_rdAccPrev;
    logic            r_wrAccPrev;
    logic            r_rdData;
    logic            r_wrData;
    logic [7:0]      r_din;
    logic [4:0]      r_op;
    logic [3:0]      r_nparam;
    logic [2:0]      r_nres;
    logic [CW-1:0]   r_cnt;
    logic [2:0]      r_idx;
    logic [2:0]      r_hdus;
    logic [2:0]      r_intHdus;
    logic [7:0]      r_c;
    logic [7:0]      r_h;
    logic [7:0]      r_r;
    logic [7:0]      r_n;
    logic            r_sisInt;
    logic            r_intPending;

    logic            w_sel;
    logic            w_rdAcc;
    logic            w_wrAcc;
    logic            w_rdCommit;
    logic            w_wrCommit;
    logic [3:0]      w_tblParam;
    logic [2:0]      w_tblRes;
    logic [7:0]      w_msr;
    logic [7:0]      w_resByte;
    logic            w_unused;

    assign w_sel      = (a[15:13] == 3'b001) && !a[1] && !iorq_n;
    assign w_rdAcc    = w_sel && !rd_n;
    assign w_wrAcc    = w_sel && !wr_n;
    // Commit on the trailing edge so a stretched strobe produces exactly one event
    assign w_rdCommit = r_rdAccPrev && !w_rdAcc;
    assign w_wrCommit = r_wrAccPrev && !w_wrAcc;
    assign w_unused   = &{1'b0, a[11:2], a[0]};

    always_comb begin
        w_tblParam = 4'd0;
        w_tblRes   = 3'd1;
        case (r_din[4:0])
            5'h03, 5'h0F: begin w_tblParam = 4'd2; w_tblRes = 3'd0; end
            5'h04:        begin w_tblParam = 4'd1; w_tblRes = 3'd1; end
            5'h07:        begin w_tblParam = 4'd1; w_tblRes = 3'd0; end
            5'h08:        begin w_tblParam = 4'd0; w_tblRes = r_intPending ? 3'd2 : 3'd1; end
            5'h0A:        begin w_tblParam = 4'd1; w_tblRes = 3'd7; end
            5'h0D:        begin w_tblParam = 4'd5; w_tblRes = 3'd7; end
            5'h02, 5'h05, 5'h06, 5'h09, 5'h0C, 5'h11, 5'h19, 5'h1D:
                          begin w_tblParam = 4'd8; w_tblRes = 3'd7; end
            default:      begin w_tblParam = 4'd0; w_tblRes = 3'd1; end
        endcase
    end

    always_comb begin
        w_resByte = 8'h80;
        if (r_nres == 3'd7) begin
            case (r_idx)
                3'd0:    w_resByte = 8'h48 | {5'b0, r_hdus};
                3'd3:    w_resByte = r_c;
                3'd4:    w_resByte = r_h;
                3'd5:    w_resByte = r_r;
                3'd6:    w_resByte = r_n;
                default: w_resByte = 8'h00;
            endcase
        end else if (r_op == 5'h04) begin
            w_resByte = 8'h10 | {5'b0, r_hdus};
        end else if (r_op == 5'h08 && r_sisInt) begin
            w_resByte = (r_idx == 3'd0) ? (8'h68 | {5'b0, r_intHdus}) : 8'h00;
        end
    end

    always_comb begin
        w_msr = 8'h80;
        case (r_state)
            S_CMD:    w_msr = 8'h90;
            S_RESULT: w_msr = 8'hD0;
            default:  w_msr = 8'h80;
        endcase
    end

    assign oe          = w_rdAcc;
    assign dout        = !a[12] ? w_msr : ((r_state == S_RESULT) ? w_resByte : 8'hFF);
    assign int_pending = r_intPending;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_rdAccPrev  <= 1'b0;
            r_wrAccPrev  <= 1'b0;
            r_rdData     <= 1'b0;
            r_wrData     <= 1'b0;
            r_din        <= 8'h00;
            r_op         <= 5'h00;
            r_nparam     <= 4'd0;
            r_nres       <= 3'd0;
            r_cnt        <= '0;
            r_idx        <= 3'd0;
            r_hdus       <= 3'd0;
            r_intHdus    <= 3'd0;
            r_c          <= 8'h00;
            r_h          <= 8'h00;
            r_r          <= 8'h00;
            r_n          <= 8'h00;
            r_sisInt     <= 1'b0;
            r_intPending <= 1'b0;
        end else begin
            r_rdAccPrev <= w_rdAcc;
            r_wrAccPrev <= w_wrAcc;
            if (w_rdAcc) begin
                r_rdData <= a[12];
            end
            if (w_wrAcc) begin
                r_wrData <= a[12];
                r_din    <= din;
            end

            if (w_wrCommit && r_wrData) begin
                case (r_state)
                    S_IDLE: begin
                        r_op     <= r_din[4:0];
                        r_nparam <= w_tblParam;
                        r_nres   <= w_tblRes;
                        r_cnt    <= '0;
                        r_idx    <= 3'd0;
                        r_hdus   <= 3'd0;
                        r_c      <= 8'h00;
                        r_h      <= 8'h00;
                        r_r      <= 8'h00;
                        r_n      <= 8'h00;
                        r_sisInt <= (r_din[4:0] == 5'h08) && r_intPending;
                        r_state  <= (w_tblParam == 4'd0) ? S_RESULT : S_CMD;
                    end
                    S_CMD: begin
                        case (int'(r_cnt))
                            0:       r_hdus <= r_din[2:0];
                            1:       r_c    <= r_din;
                            2:       r_h    <= r_din;
                            3:       r_r    <= r_din;
                            4:       r_n    <= r_din;
                            default: ;
                        endcase
                        if (int'(r_cnt) < NCMD_MAX - 1) begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                        if (int'(r_cnt) + 1 >= int'(r_nparam)) begin
                            // Seek/recalibrate "complete" instantly and queue an interrupt
                            if (r_op == 5'h07 || r_op == 5'h0F) begin
                                r_intPending <= 1'b1;
                                r_intHdus    <= (r_cnt == '0) ? r_din[2:0] : r_hdus;
                            end
                            r_idx   <= 3'd0;
                            r_state <= (r_nres == 3'd0) ? S_IDLE : S_RESULT;
                        end
                    end
                    default: ;
                endcase
            end else if (w_rdCommit && r_rdData && r_state == S_RESULT) begin
                if (r_idx == r_nres - 3'd1) begin
                    r_state <= S_IDLE;
                    if (r_sisInt) begin
                        r_intPending <= 1'b0;
                    end
                end else begin
                    r_idx <= r_idx + 3'd1;
                end
            end
        end
    end

`ifdef FDC_MOTOR_PORT_EN
    logic w_motAcc;
    logic r_motAccPrev;
    logic r_motDin;
    logic r_motor;

    assign w_motAcc = (a[15:12] == 4'b0001) && !a[1] && !iorq_n && !wr_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_motAccPrev <= 1'b0;
            r_motDin     <= 1'b0;
            r_motor      <= 1'b0;
        end else begin
            r_motAccPrev <= w_motAcc;
            if (w_motAcc) begin
                r_motDin <= din[3];
            end
            if (r_motAccPrev && !w_motAcc) begin
                r_motor <= r_motDin;
            end
        end
    end

    assign motor_on = r_motor;
`else
    assign motor_on = 1'b0;
`endif

endmodule

// File: tb/tb_fdc_stub.sv
// Directed self-checking bench for fdc_stub: register handshake, command table, strobe edge rules, reset abort, motor port.
module tb_fdc_stub;

    logic        clk;
    logic        rst;
    logic [15:0] a;
    logic        iorq_n;
    logic        rd_n;
    logic        wr_n;
    logic [7:0]  din;
    logic [7:0]  dout;
    logic        oe;
    logic        int_pending;
    logic        motor_on;

    int          testsRun;
    int          testsFailed;
    logic [7:0]  got;
    logic        gotOe;

    fdc_stub #(.NCMD_MAX(9)) dut (
        .clk(clk),
        .rst(rst),
        .a(a),
        .iorq_n(iorq_n),
        .rd_n(rd_n),
        .wr_n(wr_n),
        .din(din),
        .dout(dout),
        .oe(oe),
        .int_pending(int_pending),
        .motor_on(motor_on)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // CPU write cycle with a strobe lasting 'hold' clocks, then idle long enough for the commit
    task automatic busWrite(input logic [15:0] addr, input logic [7:0] data, input int hold);
        @(negedge clk);
        a = addr; din = data; iorq_n = 1'b0; wr_n = 1'b0;
        repeat (hold) @(negedge clk);
        iorq_n = 1'b1; wr_n = 1'b1; a = 16'h0000;
        repeat (2) @(negedge clk);
    endtask

    // CPU read cycle; dout/oe are sampled shortly after the strobe asserts
    task automatic busRead(input logic [15:0] addr, input int hold, output logic [7:0] data, output logic oeSeen);
        @(negedge clk);
        a = addr; iorq_n = 1'b0; rd_n = 1'b0;
        #1;
        data = dout;
        oeSeen = oe;
        repeat (hold) @(negedge clk);
        iorq_n = 1'b1; rd_n = 1'b1; a = 16'h0000;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        testsRun++;
        if (oe !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_oe_idle: got %b expected 0", oe); end
        testsRun++;
        if (int_pending !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_int: got %b expected 0", int_pending); end
        testsRun++;
        if (motor_on !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_motor: got %b expected 0", motor_on); end
        busRead(16'h2FFD, 1, got, gotOe);
        testsRun++;
        if (got !== 8'h80) begin testsFailed++; $display("[TB] FAIL reset_msr: got %h expected 80", got); end
        testsRun++;
        if (gotOe !== 1'b1) begin testsFailed++; $display("[TB] FAIL reset_oe_read: got %b expected 1", gotOe); end
        busRead(16'h3FFD, 1, got, gotOe);
        testsRun++;
        if (got !== 8'hFF) begin testsFailed++; $display("[TB] FAIL reset_data: got %h expected ff", got); end
    endtask

    task automatic test_specify;
        logic [7:0] bytesIn [3] = '{8'h03, 8'hAF, 8'h03};
        logic [7:0] msrExp  [3] = '{8'h90, 8'h90, 8'h80};
        for (int i = 0; i < 3; i++) begin
            // A 4-clock strobe on the opcode must still count as a single byte
            busWrite(16'h3FFD, bytesIn[i], (i == 0) ? 4 : 1);
            busRead(16'h2FFD, 1, got, gotOe);
            testsRun++;
            if (got !== msrExp[i]) begin testsFailed++; $display("[TB] FAIL specify_msr%0d: got %h expected %h", i, got, msrExp[i]); end
            if (i == 0) begin
                busRead(16'h3FFD, 1, got, gotOe);
                testsRun++;
                if (got !== 8'hFF) begin testsFailed++; $display("[TB] FAIL specify_data_in_cmd: got %h expected ff", got); end
            end
        end
        testsRun++;
        if (int_pending !== 1'b0) begin testsFailed++; $display("[TB] FAIL specify_int: got %b expected 0", int_pending); end
    endtask

    task automatic test_sense_noint;
        busWrite(16'h3FFD, 8'h08, 1);
        busRead(16'h2FFD, 1, got, gotOe);
        testsRun++;
        if (got !== 8'hD0) begin testsFailed++; $display("[TB] FAIL sis_noint_msr: got %h expected d0", got); end
        busRead(16'h3FFD, 1, got, gotOe);
        testsRun++;
        if (got !== 8'h80) begin testsFailed++; $display("[TB] FAIL sis_noint_res: got %h expected 80", got); end
        busRead(16'h2FFD, 1, got, gotOe);
        testsRun++;
        if (got !== 8'h80) begin testsFailed++; $display("[TB] FAIL sis_noint_idle: got %h expected 80", got); end
        busWrite(16'h3FFD, 8'h1F, 1);
        busRead(16'h3FFD, 1, got, gotOe);
        testsRun++;
        if (got !== 8'h80) begin testsFailed++; $display("[TB] FAIL invalid_res: got %h expected 80", got); end
        busRead(16'h2FFD, 1, got, gotOe);
        testsRun++;
        if (got !== 8'h80) begin testsFailed++; $display("[TB] FAIL invalid_idle: got %h expected 80", got); end
    endtask

    task automatic test_recal_sense;
        busWrite(16'h3FFD, 8'h07, 1);
        testsRun++;
        if (int_pending !== 1'b0) begin testsFailed++; $display("[TB] FAIL recal_int_early: got %b expected 0", int_pending); end
        busWrite(16'h3FFD, 8'h01, 1);
        testsRun++;
        if (int_pending !== 1'b1) begin testsFailed++; $display("[TB] FAIL recal_int: got %b expected 1", int_pending); end
        busRead(16'h2FFD, 1, got, gotOe);
        testsRun++;
        if (got !== 8'h80) begin testsFailed++; $display("[TB] FAIL recal_msr: got %h expected 80", got); end
        busWrite(16'h3FFD, 8'h08, 1);
        busRead(16'h2FFD, 1, got, gotOe);
        testsRun++;
        if (got !== 8'hD0) begin testsFailed++; $display("[TB] FAIL recal_sis_msr: got %h expected d0", got); end
        busRead(16'h3FFD, 1, got, gotOe);
        testsRun++;
        if (got !== 8'h69) begin testsFailed++; $display("[TB] FAIL recal_st0: got %h expected 69", got); end
        testsRun++;
        if (int_pending !== 1'b1) begin testsFailed++; $display("[TB] FAIL recal_int_mid: got %b expected 1", int_pending); end
        busRead(16'h3FFD, 1, got, gotOe);
        testsRun++;
        if (got !== 8'h00) begin testsFailed++; $display("[TB] FAIL recal_pcn: got %h expected 00", got); end
        testsRun++;
        if (int_pending !== 1'b0) begin testsFailed++; $display("[TB] FAIL recal_int_clr: got %b expected 0", int_pending); end
        busRead(16'h2FFD, 1, got, gotOe);
        testsRun++;
        if (got !== 8'h80) begin testsFailed++; $display("[TB] FAIL recal_idle: got %h expected 80", got); end
    endtask

    task automatic test_seek_overwrite;
        busWrite(16'h3FFD, 8'h0F, 1);
        busWrite(16'h3FFD, 8'h02, 1);
        busWrite(16'h3FFD, 8'h10, 1);
        busWrite(16'h3FFD, 8'h0F, 1);
        busWrite(16'h3FFD, 8'h03, 1);
        busWrite(16'h3FFD, 8'h20, 1);
        testsRun++;
        if (int_pending !== 1'b1) begin testsFailed++; $display("[TB] FAIL seek_int: got %b expected 1", int_pending); end
        busWrite(16'h3FFD, 8'h08, 1);
        busRead(16'h3FFD, 1, got, gotOe);
        testsRun++;
        if (got !== 8'h6B) begin testsFailed++; $display("[TB] FAIL seek_st0: got %h expected 6b", got); end
        busRead(16'h3FFD, 1, got, gotOe);
        testsRun++;
        if (got !== 8'h00) begin testsFailed++; $display("[TB] FAIL seek_pcn: got %h expected 00", got); end
        testsRun++;
        if (int_pending !== 1'b0) begin testsFailed++; $display("[TB] FAIL seek_int_clr: got %b expected 0", int_pending); end
    endtask

    task automatic test_sense_drive;
        busWrite(16'h3FFD, 8'h04, 1);
        busWrite(16'h3FFD, 8'h05, 1);
        busRead(16'h3FFD, 1, got, gotOe);
        testsRun++;
        if (got !== 8'h15) begin testsFailed++; $display("[TB] FAIL sds_st3: got %h expected 15", got); end
        busRead(16'h2FFD, 1, got, gotOe);
        testsRun++;
        if (got !== 8'h80) begin testsFailed++; $display("[TB] FAIL sds_idle: got %h expected 80", got); end
    endtask

    task automatic test_read_data;
        logic [7:0] cmd    [9] = '{8'h46, 8'h00, 8'h05, 8'h01, 8'h03, 8'h02, 8'h09, 8'h2A, 8'hFF};
        logic [7:0] resExp [7] = '{8'h48, 8'h00, 8'h00, 8'h05, 8'h01, 8'h03, 8'h02};
        for (int i = 0; i < 9; i++) begin
            busWrite(16'h3FFD, cmd[i], 1);
            if (i >= 7) begin
                busRead(16'h2FFD, 1, got, gotOe);
                testsRun++;
                if (got !== ((i == 8) ? 8'hD0 : 8'h90)) begin
                    testsFailed++;
                    $display("[TB] FAIL rdata_msr_after%0d: got %h expected %h", i, got, (i == 8) ? 8'hD0 : 8'h90);
                end
            end
        end
        for (int i = 0; i < 7; i++) begin
            // Long strobe on the first read, stray data write mid-result; neither may disturb the sequence
            busRead(16'h3FFD, (i == 0) ? 5 : 1, got, gotOe);
            testsRun++;
            if (got !== resExp[i]) begin testsFailed++; $display("[TB] FAIL rdata_res%0d: got %h expected %h", i, got, resExp[i]); end
            if (i == 3) busWrite(16'h3FFD, 8'h55, 1);
        end
        busRead(16'h2FFD, 1, got, gotOe);
        testsRun++;
        if (got !== 8'h80) begin testsFailed++; $display("[TB] FAIL rdata_idle: got %h expected 80", got); end
    endtask

    task automatic test_read_id;
        logic [7:0] resExp [7] = '{8'h49, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        busWrite(16'h3FFD, 8'h0A, 1);
        busWrite(16'h3FFD, 8'h01, 1);
        for (int i = 0; i < 7; i++) begin
            busRead(16'h3FFD, 1, got, gotOe);
            testsRun++;
            if (got !== resExp[i]) begin testsFailed++; $display("[TB] FAIL readid_res%0d: got %h expected %h", i, got, resExp[i]); end
        end
        busRead(16'h2FFD, 1, got, gotOe);
        testsRun++;
        if (got !== 8'h80) begin testsFailed++; $display("[TB] FAIL readid_idle: got %h expected 80", got); end
    endtask

    task automatic test_reset_mid;
        busWrite(16'h3FFD, 8'h46, 1);
        busWrite(16'h3FFD, 8'h00, 1);
        busWrite(16'h3FFD, 8'h05, 1);
        busWrite(16'h3FFD, 8'h01, 1);
        busRead(16'h2FFD, 1, got, gotOe);
        testsRun++;
        if (got !== 8'h90) begin testsFailed++; $display("[TB] FAIL rstmid_before: got %h expected 90", got); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        busRead(16'h2FFD, 1, got, gotOe);
        testsRun++;
        if (got !== 8'h80) begin testsFailed++; $display("[TB] FAIL rstmid_msr: got %h expected 80", got); end
        busRead(16'h3FFD, 1, got, gotOe);
        testsRun++;
        if (got !== 8'hFF) begin testsFailed++; $display("[TB] FAIL rstmid_data: got %h expected ff", got); end
    endtask

    task automatic test_motor;
`ifdef FDC_MOTOR_PORT_EN
        busWrite(16'h1FFD, 8'h08, 3);
        testsRun++;
        if (motor_on !== 1'b1) begin testsFailed++; $display("[TB] FAIL motor_on: got %b expected 1", motor_on); end
        busWrite(16'h1FFD, 8'h00, 1);
        testsRun++;
        if (motor_on !== 1'b0) begin testsFailed++; $display("[TB] FAIL motor_off: got %b expected 0", motor_on); end
`else
        busWrite(16'h1FFD, 8'h08, 1);
        testsRun++;
        if (motor_on !== 1'b0) begin testsFailed++; $display("[TB] FAIL motor_tied: got %b expected 0", motor_on); end
`endif
        busRead(16'h2FFD, 1, got, gotOe);
        testsRun++;
        if (got !== 8'h80) begin testsFailed++; $display("[TB] FAIL motor_fdc_idle: got %h expected 80", got); end
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        rst    = 1'b1;
        a      = 16'h0000;
        iorq_n = 1'b1;
        rd_n   = 1'b1;
        wr_n   = 1'b1;
        din    = 8'h00;
        test_reset;
        test_specify;
        test_sense_noint;
        test_recal_sense;
        test_seek_overwrite;
        test_sense_drive;
        test_read_data;
        test_read_id;
        test_reset_mid;
        test_motor;
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
